// File: rtl/banked_data_memory.sv
// Purpose : banked 32-bit data memory, up to 4 tag-decoded segments, byte/half/word access, big-endian lanes.
// Latency : request accepted in IDLE, ack_out/readdata_out/fault_out presented 1 cycle later (RESP).
// Backpres: ready_out drops for the RESP cycle; sustained rate is one request every 2 cycles.
//
// Ports   : clock, reset (sync, active-high)
//           req_in/we_in/addr_in/size_in/writedata_in -> request, sampled when ready_out=1
//           ready_out, ack_out, readdata_out (right-justified, zero-extended), fault_out
// Config  : define BANKED_DATA_MEMORY_ALIGN_TRAP_EN to fault misaligned halfword/word accesses;
//           otherwise misaligned accesses are aligned down silently.
module banked_data_memory #(
   parameter int                      NUM_SEGS  = 2,
   parameter logic [16*NUM_SEGS-1:0]  SEG_TAGS  = {16'h7fff, 16'h1000},
   parameter int                      SEG_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_in,
   input  logic        we_in,
   input  logic [31:0] addr_in,
   input  logic [1:0]  size_in,
   input  logic [31:0] writedata_in,
   output logic        ready_out,
   output logic        ack_out,
   output logic [31:0] readdata_out,
   output logic        fault_out
);

   localparam int AW    = $clog2(SEG_WORDS);
   localparam int SW    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
   localparam int DEPTH = NUM_SEGS * SEG_WORDS;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_accept;

   logic [31:0]    r_mem [0:DEPTH-1];
   logic [31:0]    r_readdata;
   logic           r_fault;

   logic           w_hit;
   logic [SW-1:0]  w_seg;
   logic [SW+AW-1:0] w_idx;
   logic [1:0]     w_lo;
   logic           w_fault;
   logic [3:0]     w_be;
   logic [31:0]    w_wdat;
   logic [31:0]    w_word;
   logic [31:0]    w_rdat;

   // Bits between the word index and the tag are don't-care (segment wrap).
   logic           w_unused_addr;
   assign w_unused_addr = ^addr_in;

   // ---------------------------------------------------------------- decode
   // Scan from the top so the lowest-index matching tag wins.
   always_comb begin
      w_hit = 1'b0;
      w_seg = '0;
      for (int i = NUM_SEGS - 1; i >= 0; i--) begin
         if (addr_in[31:16] == SEG_TAGS[16*i +: 16]) begin
            w_hit = 1'b1;
            w_seg = SW'(i);
         end
      end
   end

   // Segments are power-of-two sized, so concatenation gives seg*SEG_WORDS+word.
   assign w_idx  = {w_seg, addr_in[AW+1:2]};
   assign w_word = r_mem[w_idx];

   // --------------------------------------------------------- lanes / fault
   always_comb begin
      w_lo   = addr_in[1:0];
      w_be   = 4'b0000;
      w_wdat = writedata_in;
      w_rdat = 32'h0;
      w_fault = !w_hit || (size_in == 2'b10);
`ifdef BANKED_DATA_MEMORY_ALIGN_TRAP_EN
      w_fault = w_fault
              || ((size_in == 2'b11) && (addr_in[1:0] != 2'b00))
              || ((size_in == 2'b01) && addr_in[0]);
`endif
      // Big-endian: offset 0 lives in bits [31:24]; ~offset*8 is the lane's low bit.
      case (size_in)
         2'b00: begin
            w_be   = 4'b1000 >> w_lo;
            w_wdat = {4{writedata_in[7:0]}};
            w_rdat = {24'h0, w_word[{~w_lo, 3'b000} +: 8]};
         end
         2'b01: begin
            w_lo   = {addr_in[1], 1'b0};
            w_be   = addr_in[1] ? 4'b0011 : 4'b1100;
            w_wdat = {2{writedata_in[15:0]}};
            w_rdat = {16'h0, w_word[{~addr_in[1], 4'b0000} +: 16]};
         end
         2'b11: begin
            w_lo   = 2'b00;
            w_be   = 4'b1111;
            w_wdat = writedata_in;
            w_rdat = w_word;
         end
         default: begin
            w_be   = 4'b0000;
         end
      endcase
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_out   = 1'b0;
      ack_out     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_out = 1'b1;
            w_accept  = req_in && !reset;
            if (req_in) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            ack_out     = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- response regs
   // Captured at acceptance and held until the next response or reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_readdata <= 32'h0;
         r_fault    <= 1'b0;
      end else if (w_accept) begin
         r_fault    <= w_fault;
         r_readdata <= (w_fault || we_in) ? 32'h0 : w_rdat;
      end
   end

   assign readdata_out = r_readdata;
   assign fault_out    = r_fault;

   // --------------------------------------------------------------- memory
   // No reset: contents survive reset; writes commit on the acceptance edge.
   always_ff @(posedge clock) begin
      if (w_accept && we_in && !w_fault) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
               r_mem[w_idx][8*k +: 8] <= w_wdat[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_banked_data_memory.sv
// Purpose : self-checking bench for banked_data_memory against a byte-addressed reference model.
// Latency : each request is checked for ack exactly one cycle after acceptance.
// Backpres: requests are only issued while ready_out is expected high.
module tb_banked_data_memory;

   logic        clock;
   logic        reset;
   logic        req_in;
   logic        we_in;
   logic [31:0] addr_in;
   logic [1:0]  size_in;
   logic [31:0] writedata_in;
   logic        ready_out;
   logic        ack_out;
   logic [31:0] readdata_out;
   logic        fault_out;

   int checks;
   int errors;

   // Reference model: big-endian byte store, key = segment*4096 + in-segment byte offset.
   bit [7:0] mem_m [int];

   banked_data_memory dut (
      .clock        (clock),
      .reset        (reset),
      .req_in       (req_in),
      .we_in        (we_in),
      .addr_in      (addr_in),
      .size_in      (size_in),
      .writedata_in (writedata_in),
      .ready_out    (ready_out),
      .ack_out      (ack_out),
      .readdata_out (readdata_out),
      .fault_out    (fault_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit we, input bit [31:0] addr, input bit [1:0] size,
                        input bit [31:0] wd, output bit [31:0] rd, output bit flt,
                        output bit known);
      int       base;
      int       n;
      bit [1:0] lo;
      rd    = 32'h0;
      known = 1'b1;
      if (addr[31:16] == 16'h1000)      base = 0;
      else if (addr[31:16] == 16'h7fff) base = 4096;
      else                              base = -1;
      lo  = addr[1:0];
      n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      flt = (base < 0) || (size == 2'b10);
`ifdef BANKED_DATA_MEMORY_ALIGN_TRAP_EN
      flt = flt || ((size == 2'b11) && (lo != 2'b00)) || ((size == 2'b01) && lo[0]);
`endif
      if (flt) return;
      if (size == 2'b11)      lo = 2'b00;
      else if (size == 2'b01) lo[0] = 1'b0;
      base = base + int'(addr[11:2]) * 4 + int'(lo);
      if (we) begin
         known = 1'b0;
         for (int i = 0; i < n; i++) mem_m[base + i] = wd[8*(n-1-i) +: 8];
      end else begin
         for (int i = 0; i < n; i++) begin
            if (!mem_m.exists(base + i)) known = 1'b0;
            else rd = {rd[23:0], mem_m[base + i]};
         end
      end
   endtask

   // Issue one request from IDLE (called at posedge+1) and check the response cycle.
   task automatic do_req(input string tag, input bit we, input bit [31:0] addr,
                         input bit [1:0] size, input bit [31:0] wd,
                         output logic [31:0] rd, output logic flt);
      bit [31:0] e_rd;
      bit        e_flt;
      bit        e_known;
      model(we, addr, size, wd, e_rd, e_flt, e_known);
      chk({tag, ".ready"}, {31'h0, ready_out}, 32'd1);
      req_in = 1'b1; we_in = we; addr_in = addr; size_in = size; writedata_in = wd;
      @(posedge clock); #1;
      req_in = 1'b0;
      chk({tag, ".ack"}, {31'h0, ack_out}, 32'd1);
      chk({tag, ".busy"}, {31'h0, ready_out}, 32'd0);
      chk({tag, ".fault"}, {31'h0, fault_out}, {31'h0, e_flt});
      if (e_known) chk({tag, ".rdata"}, readdata_out, e_rd);
      rd  = readdata_out;
      flt = fault_out;
      @(posedge clock); #1;
      chk({tag, ".ackdrop"}, {31'h0, ack_out}, 32'd0);
      if (e_known) chk({tag, ".hold"}, readdata_out, e_rd);
   endtask

   logic [31:0] rd;
   logic        flt;
   bit [31:0]   e_rd;
   bit          e_flt;
   bit          e_known;
   bit [31:0]   a;

   initial begin
      checks = 0; errors = 0;
      reset = 1'b1; req_in = 1'b1; we_in = 1'b1; addr_in = 32'h1000_0000;
      size_in = 2'b11; writedata_in = 32'hFFFF_FFFF;

      // Reset state (req_in high during reset must be ignored)
      repeat (2) @(posedge clock);
      #1;
      chk("rst.ready", {31'h0, ready_out}, 32'd1);
      chk("rst.ack", {31'h0, ack_out}, 32'd0);
      chk("rst.fault", {31'h0, fault_out}, 32'd0);
      chk("rst.rdata", readdata_out, 32'h0);
      reset = 1'b0; req_in = 1'b0;
      @(posedge clock); #1;

      // Preload words 0..7 of both segments so every later read is known
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < 8; w++) begin
            a = {(s == 0) ? 16'h1000 : 16'h7fff, 11'h0, 3'(w), 2'b00};
            do_req("init", 1'b1, a, 2'b11, $urandom, rd, flt);
         end
      end

      // Word write then read back
      do_req("w31", 1'b1, 32'h1000_0004, 2'b11, 32'hDEAD_BEEF, rd, flt);
      do_req("r31", 1'b0, 32'h1000_0004, 2'b11, 32'h0, rd, flt);
      chk("r31.lit", rd, 32'hDEAD_BEEF);
      chk("r31.litf", {31'h0, flt}, 32'd0);

      // Byte merge, big-endian lane
      do_req("w32", 1'b1, 32'h1000_0005, 2'b00, 32'h0000_0055, rd, flt);
      do_req("r32w", 1'b0, 32'h1000_0004, 2'b11, 32'h0, rd, flt);
      chk("r32w.lit", rd, 32'hDE55_BEEF);
      do_req("r32b", 1'b0, 32'h1000_0005, 2'b00, 32'h0, rd, flt);
      chk("r32b.lit", rd, 32'h0000_0055);

      // Faults: unmapped and reserved size
      do_req("r33u", 1'b0, 32'h2000_0000, 2'b11, 32'h0, rd, flt);
      chk("r33u.litf", {31'h0, flt}, 32'd1);
      chk("r33u.lit", rd, 32'h0);
      do_req("w33s", 1'b1, 32'h1000_0000, 2'b10, 32'h1234_5678, rd, flt);
      chk("w33s.litf", {31'h0, flt}, 32'd1);
      do_req("r33s", 1'b0, 32'h1000_0000, 2'b11, 32'h0, rd, flt);

      // Halfword alignment
      do_req("w34", 1'b1, 32'h7fff_0000, 2'b11, 32'hCAFE_F00D, rd, flt);
      do_req("r34a", 1'b0, 32'h7fff_0002, 2'b01, 32'h0, rd, flt);
      chk("r34a.lit", rd, 32'h0000_F00D);
      chk("r34a.litf", {31'h0, flt}, 32'd0);
      do_req("r34m", 1'b0, 32'h7fff_0003, 2'b01, 32'h0, rd, flt);
`ifdef BANKED_DATA_MEMORY_ALIGN_TRAP_EN
      chk("r34m.litf", {31'h0, flt}, 32'd1);
`else
      chk("r34m.lit", rd, 32'h0000_F00D);
`endif

      // Segment wrap
      do_req("w36", 1'b1, 32'h1000_0000, 2'b11, 32'h1357_9BDF, rd, flt);
      do_req("r36", 1'b0, 32'h1000_1000, 2'b11, 32'h0, rd, flt);
      chk("r36.lit", rd, 32'h1357_9BDF);

      // Reset overrides a request in the same cycle: nothing written
      reset = 1'b1; req_in = 1'b1; we_in = 1'b1; addr_in = 32'h1000_000C;
      size_in = 2'b11; writedata_in = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      chk("rovr.ack", {31'h0, ack_out}, 32'd0);
      chk("rovr.ready", {31'h0, ready_out}, 32'd1);
      reset = 1'b0; req_in = 1'b0;
      do_req("rovr.rd", 1'b0, 32'h1000_000C, 2'b11, 32'h0, rd, flt);

      // Reset during RESP: ack dropped, write stays committed
      model(1'b1, 32'h1000_0008, 2'b11, 32'hA5A5_A5A5, e_rd, e_flt, e_known);
      req_in = 1'b1; we_in = 1'b1; addr_in = 32'h1000_0008; size_in = 2'b11;
      writedata_in = 32'hA5A5_A5A5;
      @(posedge clock); #1;
      chk("rresp.ack", {31'h0, ack_out}, 32'd1);
      reset = 1'b1; req_in = 1'b0;
      @(posedge clock); #1;
      chk("rresp.noack", {31'h0, ack_out}, 32'd0);
      chk("rresp.ready", {31'h0, ready_out}, 32'd1);
      chk("rresp.rdata", readdata_out, 32'h0);
      reset = 1'b0;
      do_req("rresp.rd", 1'b0, 32'h1000_0008, 2'b11, 32'h0, rd, flt);
      chk("rresp.lit", rd, 32'hA5A5_A5A5);

      // req_in held high: ready/ack alternate; reset in the last RESP
      model(1'b0, 32'h1000_0004, 2'b11, 32'h0, e_rd, e_flt, e_known);
      req_in = 1'b1; we_in = 1'b0; addr_in = 32'h1000_0004; size_in = 2'b11;
      for (int k = 0; k < 7; k++) begin
         @(posedge clock); #1;
         chk("tput.ack", {31'h0, ack_out}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("tput.ready", {31'h0, ready_out}, (k % 2 == 0) ? 32'd0 : 32'd1);
         if (k % 2 == 0) chk("tput.rdata", readdata_out, e_rd);
      end
      reset = 1'b1; req_in = 1'b0;
      @(posedge clock); #1;
      chk("tput.rstack", {31'h0, ack_out}, 32'd0);
      chk("tput.rstready", {31'h0, ready_out}, 32'd1);
      reset = 1'b0;

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         int t;
         t = $urandom_range(0, 4);
         a[31:16] = (t < 2) ? 16'h1000 : (t < 4) ? 16'h7fff : 16'h2000;
         a[15:12] = 4'($urandom_range(0, 15));
         a[11:5]  = 7'h0;
         a[4:2]   = 3'($urandom_range(0, 7));
         a[1:0]   = 2'($urandom_range(0, 3));
         do_req("rnd", 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom, rd, flt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/banked_data_memory.md
BANKED_DATA_MEMORY -- requirements
Module: banked_data_memory

Interface
REQ-001 Parameter NUM_SEGS, default 2: number of memory segments; legal range 1-4.
REQ-002 Parameter SEG_TAGS, default {16'h7fff,16'h1000}: packed 16-bit upper-address tags; segment i uses bits [16i+15:16i].
REQ-003 Parameter SEG_WORDS, default 1024: 32-bit words per segment; power of two, at most 16384.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_in  input  1  request strobe; accepted only when ready_out=1.
REQ-007 we_in  input  1  1=write, 0=read; sampled at acceptance.
REQ-008 addr_in  input  32  byte address; sampled at acceptance.
REQ-009 size_in  input  2  access size: 00=byte, 01=halfword, 11=word, 10=reserved.
REQ-010 writedata_in  input  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-011 ready_out  output  1  block can accept a request this cycle.
REQ-012 ack_out  output  1  one-cycle completion pulse for the accepted request.
REQ-013 readdata_out  output  32  read result, right-justified and zero-extended; valid when ack_out=1 on a read.
REQ-014 fault_out  output  1  qualifies ack_out: request was unmapped, reserved-size or misaligned.

Function
REQ-015 FSM states: IDLE (ready_out=1, ack_out=0) and RESP (ready_out=0, ack_out=1).
REQ-016 IDLE with req_in=1: go to RESP on the next edge; otherwise stay in IDLE.
REQ-017 RESP always returns to IDLE on the next edge; sustained throughput is one request per 2 cycles.
REQ-018 Decode: addr_in[31:16] is matched against each tag; the lowest-index matching segment is selected.
REQ-019 Word index is addr_in[log2(SEG_WORDS)+1:2]; addresses wrap within a segment; intermediate address bits are ignored.
REQ-020 Byte lanes are big-endian: addr[1:0]=0 selects bits [31:24]; halfword addr[1]=0 selects [31:16].
REQ-021 Writes commit on the acceptance edge to the addressed lanes only; other lanes of the word are unchanged.
REQ-022 Reads use synchronous memory; readdata_out is registered and presented in RESP (latency 1 cycle from acceptance).
REQ-023 Fault conditions: no tag match, or size_in=10; a faulting request writes nothing and returns readdata_out=0 with fault_out=1.
REQ-024 readdata_out and fault_out hold their values outside RESP until the next response.
REQ-025 Read-after-write to the same address in consecutive requests returns the newly written data.

Reset
REQ-026 reset=1 at an edge forces IDLE, ack_out=0, fault_out=0 and readdata_out=0; it overrides req_in in the same cycle.
REQ-027 Reset during RESP drops the pending ack; a write already committed stays committed.
REQ-028 Memory contents are not cleared by reset.

Configuration
REQ-029 Macro BANKED_DATA_MEMORY_ALIGN_TRAP_EN defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 faults (no write, fault_out=1).
REQ-030 Macro not defined: misaligned low address bits are forced to zero (access aligned down) and no fault is raised.

Verification
REQ-031 Word write 0xDEADBEEF @0x10000004, then word read @0x10000004 -> ack 1 cycle after acceptance, readdata 0xDEADBEEF, fault 0.
REQ-032 Byte write 0x55 @0x10000005 over 0xDEADBEEF, then word read -> 0xDE55BEEF; byte read @0x10000005 -> 0x00000055.
REQ-033 Read @0x20000000 -> fault_out=1, readdata 0; size_in=10 @0x10000000 -> fault_out=1, memory unchanged.
REQ-034 Halfword read @0x7fff0002 with ALIGN_TRAP_EN defined -> fault_out=0; with @0x7fff0003 -> fault_out=1 (defined) or data from 0x7fff0002 (undefined).
REQ-035 req_in held high continuously -> ready/ack alternate every cycle; assert reset in RESP -> no ack, ready_out=1 the next cycle.
REQ-036 Wrap check (SEG_WORDS=1024): write @0x10000000, read @0x10001000 -> same data.
